int_to_fp: RTL and testbench

Sequential converter from 16-bit integer (unsigned or two's-complement) to the 22-bit float format (sign, 5-bit biased exponent, 16-bit mantissa with explicit leading one at bit 15). It is the inverse of the float-to-integer stage, so integer results feed back into the float datapath without loss. An iterative one-bit-per-cycle normalizer is wrapped in valid/ready handshakes on both sides.

---
 rtl/int_fp_pkg.sv | 15 +
 rtl/int_to_fp.sv | 73 +++++++
 tb/tb_int_to_fp.sv | 133 +++++++++++++
 3 files changed

// File: rtl/int_fp_pkg.sv
// int_fp_pkg: shared widths, bias, field positions and FSM states for the int/float converters.
package int_fp_pkg;
  localparam int INT_W = 16;
  localparam int EXP_W = 5;
  localparam int MANT_W = 16;
  localparam int FP_W = 22;
  localparam int EXP_BIAS = 15;
  localparam int EXP_MAX_INT = 30;
  localparam int SIGN_BIT = FP_W - 1;
  localparam int EXP_HI = FP_W - 2;
  localparam int EXP_LO = MANT_W;
  localparam int MANT_HI = MANT_W - 1;
  localparam int MANT_LO = 0;
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_e;
endpackage

// File: rtl/int_to_fp.sv
// int_to_fp: iterative 16-bit integer to 22-bit float converter, one normalizing shift per cycle.
module int_to_fp
  import int_fp_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [INT_W-1:0]  i_int,
  input  logic              i_signed,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [FP_W-1:0]   o_fp,
  output logic              o_busy
);
  state_e state_q, state_d;
  logic [INT_W-1:0] mag_q, mag_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic sign_q, sign_d;
  logic [FP_W-1:0] fp_q, fp_d;
  logic valid_q, valid_d;
  assign o_ready = state_q == IDLE;
  assign o_busy = state_q != IDLE;
  assign o_valid = valid_q;
  assign o_fp = fp_q;
  always_comb begin
    state_d = state_q;
    mag_d = mag_q;
    exp_d = exp_q;
    sign_d = sign_q;
    fp_d = fp_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: if (i_valid) begin
        sign_d = i_signed & i_int[INT_W-1];
        mag_d = sign_d ? ~i_int + 1'b1 : i_int;
        exp_d = EXP_W'(EXP_MAX_INT);
        state_d = NORM;
      end
      NORM: if (mag_q == '0 || mag_q[INT_W-1]) begin
        // zero is encoded as all-zero bits regardless of sign
        fp_d = mag_q == '0 ? '0 : {sign_q, exp_q, mag_q};
        valid_d = 1'b1;
        state_d = DONE;
      end else begin
        mag_d = mag_q << 1;
        exp_d = exp_q - 1'b1;
      end
      DONE: if (i_ready) begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      mag_q <= '0;
      exp_q <= '0;
      sign_q <= 1'b0;
      fp_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q <= mag_d;
      exp_q <= exp_d;
      sign_q <= sign_d;
      fp_q <= fp_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_int_to_fp.sv
// tb_int_to_fp: directed and random scoreboard bench for int_to_fp.
module tb_int_to_fp;
  import int_fp_pkg::*;
  logic i_clk = 0, i_rst = 1, i_valid = 0, i_signed = 0, i_ready = 0;
  logic [15:0] i_int = 0;
  logic o_ready, o_valid, o_busy;
  logic [21:0] o_fp;
  int passed = 0, total = 0;
  logic [21:0] q_fp[$];
  int q_lat[$];
  int_to_fp dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_int(i_int), .i_signed(i_signed), .o_valid(o_valid), .i_ready(i_ready),
    .o_fp(o_fp), .o_busy(o_busy)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  function automatic logic [21:0] model(input logic [15:0] v, input bit s, output int lat);
    logic [15:0] m;
    bit sg;
    int p;
    sg = s && v[15];
    m = sg ? 16'(0 - v) : v;
    p = -1;
    for (int i = 0; i < 16; i++) if (m[i]) p = i;
    if (p < 0) begin
      lat = 1;
      return 22'h0;
    end
    lat = 16 - p;
    return {sg, 5'(15 + p), 16'(m << (15 - p))};
  endfunction
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask
  task automatic convert(input logic [15:0] v, input bit s, input int hold, input bit busy_chk);
    int lat, e_lat;
    logic [21:0] e_fp;
    logic [15:0] mag;
    e_fp = model(v, s, e_lat);
    q_fp.push_back(e_fp);
    q_lat.push_back(e_lat);
    mag = (s && v[15]) ? 16'(0 - v) : v;
    chk("ready_before_accept", o_ready, 1);
    i_valid = 1;
    i_int = v;
    i_signed = s;
    step();
    i_valid = 0;
    i_int = 16'($urandom);
    i_signed = 1'($urandom);
    lat = 0;
    while (!o_valid && lat < 40) begin
      if (busy_chk) chk("busy_in_norm", o_busy, 1);
      step();
      lat++;
    end
    chk("valid_timeout", o_valid, 1);
    e_fp = q_fp.pop_front();
    e_lat = q_lat.pop_front();
    chk($sformatf("fp_%h_s%0d", v, s), o_fp, e_fp);
    chk($sformatf("lat_%h_s%0d", v, s), lat, e_lat);
    if (o_fp != 0) chk("round_trip", 32'(o_fp[MANT_HI:MANT_LO] >> (EXP_MAX_INT - int'(o_fp[EXP_HI:EXP_LO])) ), 32'(mag));
    for (int i = 0; i < hold; i++) begin
      i_valid = 1'($urandom);
      i_int = 16'($urandom);
      step();
      chk("hold_fp", o_fp, e_fp);
      chk("hold_valid", o_valid, 1);
      chk("hold_ready", o_ready, 0);
    end
    i_valid = 0;
    i_ready = 1;
    step();
    i_ready = 0;
    chk("post_ready", o_ready, 1);
    chk("post_valid", o_valid, 0);
  endtask
  initial begin
    bit seen;
    step();
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_fp", o_fp, 0);
    i_rst = 0;
    step();
    convert(16'h0001, 0, 0, 1);
    convert(16'hFFFF, 0, 0, 0);
    convert(16'h0300, 0, 0, 0);
    convert(16'hFFFF, 1, 0, 0);
    convert(16'h8000, 1, 0, 0);
    convert(16'h8000, 0, 0, 0);
    convert(16'h0000, 1, 0, 0);
    convert(16'h0000, 0, 0, 0);
    convert(16'h1234, 0, 5, 0);
    i_valid = 1;
    i_int = 16'h0001;
    i_signed = 0;
    step();
    i_valid = 0;
    repeat (4) step();
    chk("mid_norm_busy", o_busy, 1);
    i_rst = 1;
    #1;
    chk("async_rst_ready", o_ready, 1);
    step();
    i_rst = 0;
    chk("abort_valid", o_valid, 0);
    chk("abort_ready", o_ready, 1);
    chk("abort_fp", o_fp, 0);
    chk("abort_busy", o_busy, 0);
    seen = 0;
    repeat (20) begin
      step();
      if (o_valid) seen = 1;
    end
    chk("abort_no_pulse", seen, 0);
    convert(16'h00FF, 0, 0, 0);
    for (int k = 0; k < 1500; k++) convert(16'($urandom), 1'($urandom), $urandom_range(0, 2), 0);
    for (int k = 0; k < 16; k++) begin
      convert(16'(1 << k), 0, 0, 0);
      convert(16'(0 - (1 << k)), 1, 0, 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
